// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings (also used by the ALU control
// decoder) and the iterative execution unit's FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } alu_state_e;

    // Shift ops take the bit-serial path; everything else completes in one cycle.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Result register plus bit-serial shifter. A load writes the register
// directly, which also serves the single-cycle ops. Each step shifts by one
// bit and decrements the remaining count.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [XLEN-1:0]    load_data_i,
    input  logic [SHAMT_W-1:0] load_cnt_i,
    input  logic               step_i,
    input  logic [3:0]         shift_op_i,
    output logic [XLEN-1:0]    data_o,
    output logic               zero_o,
    output logic               last_o
);

    logic [XLEN-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               zero_q;

    // Next-state: load wins over step; one-bit shift per step.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = load_cnt_i;
        end else if (step_i) begin
            case (shift_op_i)
                ALU_SLL: data_d = {data_q[XLEN-2:0], 1'b0};
                ALU_SRA: data_d = {data_q[XLEN-1], data_q[XLEN-1:1]};
                default: data_d = {1'b0, data_q[XLEN-1:1]};
            endcase
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    // State registers; zero flag is registered alongside the result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            zero_q <= (data_d == '0);
        end
    end

    assign data_o = data_q;
    assign zero_o = zero_q;
    assign last_o = (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/alu_iter_exec.sv
// Area-reduced ALU execution stage: logic/add/sub in one cycle, shifts one
// bit per cycle, valid/ready handshake on both sides.
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      alu_control_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    alu_state_e         state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               illegal_q, illegal_d;
    logic               load, step, last;
    logic [SHAMT_W-1:0] load_cnt;
    logic [XLEN-1:0]    alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = operand_b_i[SHAMT_W-1:0];

    // Single-cycle unit; shifts pass operand_a through as the shift seed.
    always_comb begin
        alu_res = '0;
        case (alu_control_op_i)
            ALU_AND: alu_res = operand_a_i & operand_b_i;
            ALU_OR:  alu_res = operand_a_i | operand_b_i;
            ALU_ADD: alu_res = operand_a_i + operand_b_i;
            ALU_XOR: alu_res = operand_a_i ^ operand_b_i;
            ALU_SUB: alu_res = operand_a_i - operand_b_i;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = operand_a_i;
            default: alu_res = '0;
        endcase
    end

    // FSM next-state and shifter control; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        load      = 1'b0;
        load_cnt  = '0;
        step      = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        load      = 1'b1;
                        op_d      = alu_control_op_i;
                        illegal_d = alu_control_op_i[3];
                        if (is_shift(alu_control_op_i) && (shamt != '0)) begin
                            load_cnt = shamt;
                            state_d  = StShift;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StShift: begin
                    step = 1'b1;
                    if (last) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM and captured-op registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            op_q      <= ALU_AND;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load),
        .load_data_i (alu_res),
        .load_cnt_i  (load_cnt),
        .step_i      (step),
        .shift_op_i  (op_q),
        .data_o      (result_o),
        .zero_o      (zero_o),
        .last_o      (last)
    );

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Scoreboard bench for alu_iter_exec: stimulus pushes model expectations,
// an independent monitor pops and checks on each new result.
module tb_alu_iter_exec;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  alu_control_op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_iter_exec #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .alu_control_op_i (alu_control_op_i),
        .operand_a_i      (operand_a_i),
        .operand_b_i      (operand_b_i),
        .flush_i          (flush_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .result_o         (result_o),
        .zero_o           (zero_o),
        .illegal_o        (illegal_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the op table.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        int   sh;
        sh    = int'(b[4:0]);
        e.ill = 1'b0;
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: e.res = a + b;
            4'd3: e.res = a ^ b;
            4'd4: e.res = a << sh;
            4'd5: e.res = a >> sh;
            4'd6: e.res = a - b;
            4'd7: e.res = $signed(a) >>> sh;
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.zero  = (e.res == 32'd0);
        e.lat   = ((op == 4'd4 || op == 4'd5 || op == 4'd7) && sh != 0) ? sh + 1 : 1;
        e.start = 0;
        return e;
    endfunction

    // Monitor: check every new result against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid_o && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("zero", {31'd0, zero_o}, {31'd0, e.zero});
                chk("illegal", {31'd0, illegal_o}, {31'd0, e.ill});
                chk("latency", cyc - e.start, e.lat);
            end
        end
        prev_valid <= out_valid_o;
    end

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        exp_t e;
        int   n;
        chk("in_ready_idle", {31'd0, in_ready_o}, 32'd1);
        e       = model(op, a, b);
        e.start = cyc;
        sb.push_back(e);
        alu_control_op_i = op;
        operand_a_i      = a;
        operand_b_i      = b;
        in_valid_i       = 1'b1;
        out_ready_i      = (hold == 0);
        @(negedge clk);
        in_valid_i  = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        n = 0;
        while (!out_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_o) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid_i       = 1'b1;
            alu_control_op_i = 4'($urandom_range(0, 15));
            operand_a_i      = $urandom;
            operand_b_i      = $urandom;
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
            chk("hold_ready", {31'd0, in_ready_o}, 32'd0);
            chk("hold_result", result_o, e.res);
            chk("hold_zero", {31'd0, zero_o}, {31'd0, e.zero});
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("done_to_idle_valid", {31'd0, out_valid_o}, 32'd0);
        chk("done_to_idle_ready", {31'd0, in_ready_o}, 32'd1);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_i            = 1'b1;
        in_valid_i       = 1'b0;
        alu_control_op_i = 4'd0;
        operand_a_i      = 32'd0;
        operand_b_i      = 32'd0;
        flush_i          = 1'b0;
        out_ready_i      = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", {31'd0, zero_o}, 32'd1);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        rst_i = 1'b0;
        @(negedge clk);

        // Directed cases.
        issue(4'b0010, 32'h5, 32'h7, 0);
        issue(4'b0110, 32'h5, 32'h7, 0);
        issue(4'b0110, 32'h1234, 32'h1234, 0);
        issue(4'b0111, 32'h8000_0000, 32'd4, 0);
        issue(4'b0101, 32'h8000_0000, 32'd4, 0);
        issue(4'b0100, 32'h1, 32'h3F, 0);
        issue(4'b0100, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0);
        issue(4'b0011, 32'h0F0F_0000, 32'h1234, 10);

        // Flush three cycles into a 20-bit shift.
        alu_control_op_i = 4'b0100;
        operand_a_i      = 32'h0000_0001;
        operand_b_i      = 32'd20;
        in_valid_i       = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_ready", {31'd0, in_ready_o}, 32'd1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid_o) chk("flush_no_valid", 32'd1, 32'd0);
        end
        issue(4'b0011, 32'hFF00_FF00, 32'h0F0F_0F0F, 0);

        // Flush in idle with a request pending: nothing accepted, result kept.
        flush_i          = 1'b1;
        in_valid_i       = 1'b1;
        alu_control_op_i = 4'b0010;
        @(negedge clk);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("idle_flush_ready", {31'd0, in_ready_o}, 32'd1);
        chk("idle_flush_valid", {31'd0, out_valid_o}, 32'd0);
        chk("idle_flush_result", result_o, 32'hF00F_F00F);

        issue(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 1);

        // Asynchronous reset between edges during a shift.
        alu_control_op_i = 4'b0111;
        operand_a_i      = 32'h8000_0000;
        operand_b_i      = 32'd20;
        in_valid_i       = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_result", result_o, 32'd0);
        chk("arst_zero", {31'd0, zero_o}, 32'd1);
        chk("arst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("arst_illegal", {31'd0, illegal_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Randomised ops with random backpressure.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 8));
            if (op == 4'd8) op = 4'($urandom_range(8, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            issue(op, a, b, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
